fetch_packet_splitter: RTL
==========================

Name: fetch_packet_splitter

Overview:
- Sits between the instruction-fetch return path and the per-instruction FWFT skid buffer ahead of decode.
- Accepts one 64-bit aligned fetch packet (two 32-bit instruction slots) per handshake.
- Emits one instruction per cycle with its own PC and fault flag over a valid/ready interface.
- Handles entry at the odd slot after a redirect, and drops queued slots on flush.

Parameters:
PC_WIDTH, 64, width of fetch and instruction PCs

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  pipeline redirect; discard all held slots
f_pc  input  PC_WIDTH  PC of first valid slot; bit 2 selects start slot; bits 1:0 ignored
f_instr  input  64  slot0 = [31:0], slot1 = [63:32]
f_page_fault  input  1  fetch fault for this packet
f_valid  input  1  packet valid
f_ready  output  1  packet accepted when f_valid && f_ready
d_pc  output  PC_WIDTH  PC of presented instruction
d_instr  output  32  presented instruction
d_page_fault  output  1  fault flag of presented instruction
d_valid  output  1  instruction valid
d_ready  input  1  downstream accepts when d_valid && d_ready

Behaviour:
- Interface: clk and synchronous active-high rst; one clock domain.
- State register with three states:
  - EMPTY: nothing held.
  - SLOT0: slot0 is pending; slot1 follows.
  - SLOT1: slot1 is pending; last slot of the packet.
- Holding register stores: packet bits [PC_WIDTH-1:3], 64-bit word, fault bit.
- Reset: state=EMPTY, d_valid=0, f_ready=1. d_pc, d_instr and d_page_fault are zero after reset.
- d_valid = (state != EMPTY), registered in base configuration.
- d_pc = {held_pc[PC_WIDTH-1:3], slot, 2'b00}.
- d_instr is the held word half selected by the slot.
- d_page_fault is the held fault bit.
- f_ready = !flush && (state==EMPTY || (state==SLOT1 && d_ready) || (state==SLOT0 && held_fault && d_ready)).
  - f_ready never depends on f_valid.
- Packet acceptance:
  - Load the holding register.
  - Next state is SLOT1 if f_pc[2] is 1, else SLOT0.
  - Latency from acceptance to d_valid is 1 cycle.
- Fault packet: emits exactly one instruction, at the start slot, with d_page_fault=1. The remaining slot is discarded and the next state is EMPTY after the handshake (unless a new packet is accepted in the same cycle).
- Transitions on d_valid && d_ready:
  - SLOT0 (no fault) -> SLOT1.
  - SLOT1 or a faulted slot -> EMPTY, or the new packet's start state if f_valid && f_ready in the same cycle.
- Sustained throughput is 1 instruction/cycle with no bubble between packets (back-to-back accept on the last slot).
- Outputs stay stable while d_valid && !d_ready.
- flush has priority over every other event:
  - Next state is EMPTY; d_valid=0 in the next cycle.
  - No packet is accepted in the flush cycle.
  - A downstream handshake in the flush cycle is still counted downstream; the block takes no further action on it.
- rst asserted mid-packet drops all held slots, identical in effect to flush.

Optional Feature:
- Macro: FETCH_SPLITTER_BYPASS_EN.
- When defined, EMPTY state forwards combinationally:
  - d_valid = f_valid && !flush.
  - d_pc, d_instr and d_page_fault are taken from the f_* inputs at the start slot.
- Bypass transitions:
  - If d_ready in the same cycle, slot0 is consumed; the packet is stored and the state goes to SLOT1.
  - A slot1-start or faulted packet consumed in the same cycle leaves the state EMPTY.
  - Without d_ready, the block behaves as the base configuration.
- Bypass gives zero-latency forwarding. f_ready in EMPTY remains independent of d_ready, so no combinational loop exists.
- When undefined, all outputs are registered as described above.

Decomposition:
- Shared header of localparams:
  - INSTR_WIDTH=32, FETCH_WIDTH=64.
  - State encodings ST_EMPTY=2'd0, ST_SLOT0=2'd1, ST_SLOT1=2'd2.
- The header is reused by fetch and decode.
- No sub-module: the state machine and holding register are a single small block, and downstream buffering is the existing FWFT stage.

Test Plan:
- Aligned packet f_pc=0x8000_0000, f_instr=0x00200093_00100093, d_ready=1 -> d_pc 0x8000_0000 then 0x8000_0004; d_instr 0x00100093 then 0x00200093; f_ready high in the second cycle.
- Odd entry f_pc=0x8000_0104 -> single output d_pc=0x8000_0104, d_instr = upper half; state EMPTY afterwards.
- Back-to-back packets at 0x1000, 0x1008, 0x1010 with d_ready=1 -> d_valid stays high for 6 consecutive cycles; PCs increment by 4 with no gaps.
- Backpressure: d_ready=0 for 3 cycles while in SLOT0 -> d_pc, d_instr and d_page_fault hold; f_ready=0; on d_ready=1, resumes with slot1.
- Fault packet f_pc=0x2000, f_page_fault=1 -> exactly one output, d_pc=0x2000, d_page_fault=1; slot1 never presented.
- Flush asserted in SLOT0 while f_valid=1 -> packet not accepted; next cycle d_valid=0, state EMPTY; the following packet is accepted normally. Repeat with rst mid-packet for the same result.

Source files
------------

// File: rtl/fetch_packet_splitter_pkg.sv
// Shared fetch/decode constants: instruction and fetch-packet widths plus splitter state encodings.
package fetch_packet_splitter_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int FETCH_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_SLOT0 = 2'd1,
    ST_SLOT1 = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_packet_splitter.sv
// Splits 64-bit fetch packets into per-instruction valid/ready beats with PC and fault flag.
// Optional combinational forwarding from the EMPTY state: define FETCH_SPLITTER_BYPASS_EN.
module fetch_packet_splitter
  import fetch_packet_splitter_pkg::*;
#(
  parameter int PC_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [PC_WIDTH-1:0]    f_pc,
  input  logic [FETCH_WIDTH-1:0] f_instr,
  input  logic                   f_page_fault,
  input  logic                   f_valid,
  output logic                   f_ready,
  output logic [PC_WIDTH-1:0]    d_pc,
  output logic [INSTR_WIDTH-1:0] d_instr,
  output logic                   d_page_fault,
  output logic                   d_valid,
  input  logic                   d_ready
);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [PC_WIDTH-1:3]    r_pc_hi;
  logic [FETCH_WIDTH-1:0] r_word;
  logic                   r_fault;

  logic w_last_slot;
  logic w_f_ready;
  logic w_accept;
  logic w_d_valid;
  logic w_d_fire;
  logic w_slot;
  logic w_unused;

  // Low PC bits only address bytes inside a slot.
  assign w_unused = &{1'b0, f_pc[1:0]};

  // A faulted packet ends at its start slot, so SLOT0 is final when the held fault is set.
  assign w_last_slot = (r_state == ST_SLOT1) || ((r_state == ST_SLOT0) && r_fault);
  assign w_f_ready   = !flush && ((r_state == ST_EMPTY) || (w_last_slot && d_ready));
  assign w_accept    = f_valid && w_f_ready;

`ifdef FETCH_SPLITTER_BYPASS_EN
  assign w_d_valid = (r_state == ST_EMPTY) ? (f_valid && !flush) : 1'b1;
`else
  assign w_d_valid = (r_state != ST_EMPTY);
`endif
  assign w_d_fire = w_d_valid && d_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_EMPTY;
    end else if (w_accept) begin
      w_state_next = f_pc[2] ? ST_SLOT1 : ST_SLOT0;
`ifdef FETCH_SPLITTER_BYPASS_EN
      // Start slot consumed straight from the inputs; only an unfaulted slot1 remains.
      if ((r_state == ST_EMPTY) && d_ready) begin
        w_state_next = (f_pc[2] || f_page_fault) ? ST_EMPTY : ST_SLOT1;
      end
`endif
    end else if (w_d_fire) begin
      w_state_next = ((r_state == ST_SLOT0) && !r_fault) ? ST_SLOT1 : ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_hi <= '0;
      r_word  <= '0;
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_pc_hi <= f_pc[PC_WIDTH-1:3];
      r_word  <= f_instr;
      r_fault <= f_page_fault;
    end
  end

  always_comb begin
    w_slot       = (r_state == ST_SLOT1);
    d_pc         = {r_pc_hi, w_slot, 2'b00};
    d_instr      = w_slot ? r_word[63:32] : r_word[31:0];
    d_page_fault = r_fault;
`ifdef FETCH_SPLITTER_BYPASS_EN
    if (r_state == ST_EMPTY) begin
      d_pc         = {f_pc[PC_WIDTH-1:2], 2'b00};
      d_instr      = f_pc[2] ? f_instr[63:32] : f_instr[31:0];
      d_page_fault = f_page_fault;
    end
`endif
    d_valid = w_d_valid;
    f_ready = w_f_ready;
  end

endmodule
